// File: rtl/register_rename_if.sv
// register_rename_if: decode-side rename request, renamed result, writeback, commit and flush signals.
interface register_rename_if #(parameter int AREG_W = 5, parameter int PREG_W = 6);
  logic in_valid, in_ready, rd_we, stall_in, out_valid;
  logic [AREG_W-1:0] rs1, rs2, rd, commit_rd;
  logic [PREG_W-1:0] prs1, prs2, prd, old_prd, wb_prd, commit_prd, commit_old_prd;
  logic prs1_ready, prs2_ready, wb_valid, commit_valid, commit_rd_we, flush;
  modport master (
    output in_valid, rs1, rs2, rd, rd_we, stall_in, wb_valid, wb_prd,
           commit_valid, commit_rd, commit_prd, commit_old_prd, commit_rd_we, flush,
    input  in_ready, out_valid, prs1, prs2, prd, old_prd, prs1_ready, prs2_ready
  );
  modport slave (
    input  in_valid, rs1, rs2, rd, rd_we, stall_in, wb_valid, wb_prd,
           commit_valid, commit_rd, commit_prd, commit_old_prd, commit_rd_we, flush,
    output in_ready, out_valid, prs1, prs2, prd, old_prd, prs1_ready, prs2_ready
  );
endinterface

// File: rtl/register_rename.sv
// register_rename: single-wide rename with speculative/committed maps, circular free list and ready table.
module register_rename #(
  parameter int NUM_ARCH_REG = 32,
  parameter int NUM_PHYS_REG = 64,
  localparam int AREG_W = $clog2(NUM_ARCH_REG),
  localparam int PREG_W = $clog2(NUM_PHYS_REG),
  localparam int FL_DEPTH = NUM_PHYS_REG - NUM_ARCH_REG,
  localparam int FL_W = $clog2(FL_DEPTH)
) (
  input logic clk,
  input logic rst,
  register_rename_if.slave rr
);
  localparam logic [FL_W:0] FL_FULL = FL_DEPTH[FL_W:0];
  logic [PREG_W-1:0] spec_map [NUM_ARCH_REG];
  logic [PREG_W-1:0] com_map [NUM_ARCH_REG];
  logic [PREG_W-1:0] free_list [FL_DEPTH];
  logic [NUM_PHYS_REG-1:0] ready;
  logic [FL_W:0] head, tail, com_head, count;
  logic alloc, fire, push;
  logic [PREG_W-1:0] t1, t2, new_prd;
  assign alloc = rr.rd_we && rr.rd != '0;
  assign count = tail - head;
  assign rr.in_ready = !rr.flush && (!rr.out_valid || !rr.stall_in) && (!alloc || count != '0);
  assign fire = rr.in_valid && rr.in_ready;
  assign push = rr.commit_valid && rr.commit_rd_we && rr.commit_rd != '0;
  assign t1 = spec_map[rr.rs1];
  assign t2 = spec_map[rr.rs2];
  assign new_prd = free_list[head[FL_W-1:0]];
  // com_head tracks retired allocations so a flush can rewind head to it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_ARCH_REG; i++) begin
        spec_map[i] <= PREG_W'(i);
        com_map[i] <= PREG_W'(i);
      end
      for (int i = 0; i < FL_DEPTH; i++) free_list[i] <= PREG_W'(NUM_ARCH_REG + i);
      head <= '0;
      tail <= FL_FULL;
      com_head <= '0;
      ready <= '1;
      rr.out_valid <= 1'b0;
      rr.prs1 <= '0;
      rr.prs2 <= '0;
      rr.prd <= '0;
      rr.old_prd <= '0;
      rr.prs1_ready <= 1'b0;
      rr.prs2_ready <= 1'b0;
    end else begin
      if (push) begin
        com_map[rr.commit_rd] <= rr.commit_prd;
        free_list[tail[FL_W-1:0]] <= rr.commit_old_prd;
        tail <= tail + 1'b1;
        com_head <= com_head + 1'b1;
      end
      if (rr.flush) begin
        for (int i = 0; i < NUM_ARCH_REG; i++)
          spec_map[i] <= (push && rr.commit_rd == AREG_W'(i)) ? rr.commit_prd : com_map[i];
        head <= push ? com_head + 1'b1 : com_head;
        ready <= '1;
        rr.out_valid <= 1'b0;
      end else begin
        if (rr.wb_valid) ready[rr.wb_prd] <= 1'b1;
        if (fire) begin
          rr.out_valid <= 1'b1;
          rr.prs1 <= t1;
          rr.prs2 <= t2;
          rr.prs1_ready <= ready[t1] || (rr.wb_valid && rr.wb_prd == t1);
          rr.prs2_ready <= ready[t2] || (rr.wb_valid && rr.wb_prd == t2);
          rr.prd <= alloc ? new_prd : '0;
          rr.old_prd <= alloc ? spec_map[rr.rd] : '0;
          if (alloc) begin
            head <= head + 1'b1;
            spec_map[rr.rd] <= new_prd;
            if (new_prd != '0) ready[new_prd] <= 1'b0;
          end
        end else if (!rr.stall_in) rr.out_valid <= 1'b0;
      end
    end
  end
  always_ff @(posedge clk) if (rst && push && !(fire && alloc)) assert (count != FL_FULL);
endmodule

// File: doc/register_rename.md
# register_rename

Single-wide register rename stage of the out-of-order core, sitting between decode and the issue queue/ROB allocation. Each cycle it maps one instruction's architectural sources and destination to physical tags: a speculative map table, a circular free list of physical registers and a per-tag ready table. It produces the `prs1`/`prs2`/`prd` tags and source-ready bits that the issue queue consumes. It returns registers to the free list at commit and restores the committed state on flush.

## Interface
- `NUM_ARCH_REG`, 32, architectural registers (x0..x31)
- `NUM_PHYS_REG`, 64, physical registers; tag width `PREG_W` = log2(`NUM_PHYS_REG`) = 6
- `FL_DEPTH`, `NUM_PHYS_REG`-`NUM_ARCH_REG` = 32, free-list entries
- `clk` in 1: single clock, rising edge
- `rst` in 1: reset, asynchronous, active-low
- `in_valid` in 1: decoded instruction present
- `in_ready` out 1: rename accepts this cycle
- `rs1`, `rs2`, `rd` in 5 each: architectural source and destination registers
- `rd_we` in 1: instruction writes `rd`
- `stall_in` in 1: downstream (issue queue/ROB) cannot accept
- `out_valid` out 1: renamed instruction on output
- `prs1`, `prs2`, `prd`, `old_prd` out 6 each: physical tags; `old_prd` is the previous mapping of `rd`
- `prs1_ready`, `prs2_ready` out 1 each: source value already written
- `wb_valid` in 1, `wb_prd` in 6: writeback broadcast
- `commit_valid` in 1, `commit_rd` in 5, `commit_prd` in 6, `commit_old_prd` in 6, `commit_rd_we` in 1: in-order retirement
- `flush` in 1: mispredict/exception recovery

## Operation
- Reset state:
  - spec map and committed map both hold x*i*→p*i*.
  - Free list entry *i* = 32+*i*; head=0, tail=32 (pointers carry a wrap bit; count = tail−head = 32).
  - Ready table all 1.
  - Outputs: `out_valid`=0, all tag outputs 0, `prs*_ready`=0.
- Handshake:
  - `fire` = `in_valid` && `in_ready`.
  - `in_ready` = !`flush` && (!`out_valid` || !`stall_in`) && (!`alloc` || count≠0).
  - `alloc` = `rd_we` && `rd`≠0.
- On `fire`:
  - Sources are read from the spec map **before** the destination update, so `rs1`==`rd` yields the old tag.
  - `prs*_ready` = ready[tag] OR (`wb_valid` && `wb_prd`==tag), i.e. same-cycle writeback is bypassed.
  - If `alloc`: `prd` = freelist[head], head++, spec map[rd] ← `prd`, ready[`prd`] ← 0, `old_prd` ← previous map[rd].
  - If not `alloc`: `prd`=0, `old_prd`=0, no free-list change.
- x0 always maps to p0; ready[0] is never cleared.
- Writeback: ready[`wb_prd`] ← 1.
- Commit with `commit_rd_we` && `commit_rd`≠0:
  - committed map[`commit_rd`] ← `commit_prd`.
  - freelist[tail] ← `commit_old_prd`, tail++.
  - The freed tag becomes allocatable the cycle after commit; there is no same-cycle bypass to allocation.
- Flush:
  - spec map ← committed map, including any same-cycle commit update.
  - head ← committed head. This counter advances by one per freeing commit and resets to 0; it represents allocations that have retired.
  - Ready table all 1; `out_valid` ← 0.
  - Flush overrides same-cycle rename and writeback. Commit still applies in the flush cycle.
- Count never exceeds 32; a commit push while full is an upstream protocol error (assertion only).

## Timing
- Latency 1 cycle: `fire` in cycle N produces `out_valid` and tags registered at edge N+1.
- While `out_valid` && `stall_in`, all outputs hold unchanged and `in_ready`=0.
- Stall on empty free list applies only to allocating instructions. Non-writing instructions still rename when count=0.
- Simultaneous alloc and commit push in the same cycle: count unchanged, both pointers advance.
- Pointer wrap: index = low 5 bits; full/empty are distinguished by the wrap bit.
- Asserting `rst` at any time returns to the reset state immediately; in-flight output is discarded.

## Test plan
- Reset release, then `add x3,x1,x2` (rd_we=1) → next cycle `prs1`=1, `prs2`=2, `prd`=32, `old_prd`=3, both ready=1, count=31.
- Dependency chain: x3←p32, then `rs1`=x3 → `prs1`=32, `prs1_ready`=0. Then `wb_prd`=32 in the same cycle as a later read of x3 → ready=1 via bypass.
- Exhaustion: 32 back-to-back allocating renames give `prd`=32..63. The 33rd holds `in_ready`=0 while a non-writing instruction (`rd_we`=0) still fires. Commit of `old_prd`=5 → the stalled instruction fires next cycle with `prd`=5.
- `stall_in`=1 for 3 cycles with `out_valid`=1 → outputs stable, no head movement, then proceed.
- Flush after 4 speculative allocations with 1 committed → spec map[rd of 2nd..4th] restored to committed values, head=1, all ready=1, `out_valid`=0. Next alloc gets `prd`=33.
- x0: `rd`=0 with `rd_we`=1 → `prd`=0, count unchanged. `rs1`=0 → `prs1`=0, ready=1.
